// File: rtl/mips_cpu_lsu.sv
// rtl/mips_cpu_lsu.sv - MIPS load/store unit driving an Avalon-style data RAM
module mips_cpu_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // core request/response
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_rt,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_data,
  output logic              resp_err,
  // memory bus
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [ADDR_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic [ADDR_W-1:0] readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [ADDR_W-1:0] rt_q;

  logic              in_load;
  logic              in_store;
  logic              in_bad;

  logic [1:0]        k;
  logic [4:0]        sh_left;
  logic [4:0]        sh_right;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [ADDR_W-1:0] load_result;
  logic [3:0]        lane_en;
  logic [ADDR_W-1:0] lane_data;

  assign req_ready = (state == S_IDLE);

  // Classify the incoming request: load, store, or rejected (illegal/misaligned)
  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_bad   = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: in_load = 1'b1;
      OP_LH, OP_LHU: begin
        in_load = 1'b1;
        in_bad  = req_addr[0];
      end
      OP_LW: begin
        in_load = 1'b1;
        in_bad  = (req_addr[1:0] != 2'b00);
      end
      OP_SB: in_store = 1'b1;
      OP_SH: begin
        in_store = 1'b1;
        in_bad   = req_addr[0];
      end
      OP_SW: begin
        in_store = 1'b1;
        in_bad   = (req_addr[1:0] != 2'b00);
      end
      default: in_bad = 1'b1;
    endcase
  end

  assign k        = addr_q[1:0];
  // 8*(3-k) for LWL and 8*k for LWR; 3-k equals ~k on two bits
  assign sh_left  = {~k, 3'b000};
  assign sh_right = {k, 3'b000};

  // Lane enables and replicated store data for the latched request
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = wdata_q;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: begin
        lane_en   = 4'b0001 << k;
        lane_data = {4{wdata_q[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        lane_en   = k[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  // Bus outputs are only non-zero while a bus phase is active, so they
  // fall with state when reset is asserted mid-transaction
  always_comb begin
    read       = (state == S_READ);
    write      = (state == S_WRITE);
    address    = '0;
    byteenable = 4'b0000;
    writedata  = '0;
    if (state == S_READ || state == S_WRITE) begin
      address    = {addr_q[ADDR_W-1:2], 2'b00};
      byteenable = lane_en;
    end
    if (state == S_WRITE) begin
      writedata = lane_data;
    end
  end

  // Extract and extend/merge the returned word according to the load type
  always_comb begin
    sel_byte    = readdata[8*k +: 8];
    sel_half    = k[1] ? readdata[31:16] : readdata[15:0];
    load_result = '0;
    case (op_q)
      OP_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_result = {24'd0, sel_byte};
      OP_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_result = {16'd0, sel_half};
      OP_LW:   load_result = readdata;
      OP_LWL:  load_result = (readdata << sh_left) |
                             (rt_q & ~(32'hFFFF_FFFF << sh_left));
      OP_LWR:  load_result = (readdata >> sh_right) |
                             (rt_q & ~(32'hFFFF_FFFF >> sh_right));
      default: load_result = '0;
    endcase
  end

  // Request FSM: accept, run one bus phase, then pulse a response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rt_q       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rt_q    <= req_rt;
            if (in_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if (in_load) begin
              state <= S_READ;
            end else if (in_store) begin
              state <= S_WRITE;
            end
          end
        end
        S_READ: begin
          if (!waitrequest) begin
            state <= S_RDATA;
          end
        end
        S_RDATA: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= load_result;
          state      <= S_IDLE;
        end
        S_WRITE: begin
          if (!waitrequest) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb/tb_mips_cpu_lsu.sv - directed self-checking bench for mips_cpu_lsu
module tb_mips_cpu_lsu;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:15];

  // results of the last do_req call
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_rd;
  int          r_wr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_addr;
  logic        r_stable;

  mips_cpu_lsu #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rt      (req_rt),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple RAM slave: registered read data, disabled lanes return 0
  always @(posedge clk) begin
    if (read && !waitrequest) begin
      for (int b = 0; b < 4; b++)
        readdata[8*b +: 8] <= byteenable[b] ? mem[address[5:2]][8*b +: 8] : 8'h00;
    end
    if (write && !waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  // Issue one request at the current negedge; returns at the negedge where
  // resp_valid is seen (cycle count r_lat, accept edge = 0)
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rt,
                        input int wait_cycles);
    int wait_left;
    logic got;
    wait_left = wait_cycles;
    got = 1'b0;
    r_data = '0; r_err = 1'b0; r_lat = 0; r_rd = 0; r_wr = 0;
    r_be = '0; r_wd = '0; r_addr = '0; r_stable = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_issue op=%0d actual=%b required=1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt = rt;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'd7; req_addr = 32'hDEAD_BEEF;
    req_wdata = 32'h5A5A_5A5A; req_rt = 32'hA5A5_A5A5;
    for (int n = 1; n <= 20 && !got; n++) begin
      if (read || write) begin
        if (read) r_rd++;
        if (write) r_wr++;
        if (r_rd + r_wr == 1) begin
          r_be = byteenable; r_wd = writedata; r_addr = address;
        end else if (address !== r_addr || byteenable !== r_be || writedata !== r_wd) begin
          r_stable = 1'b0;
        end
        if (wait_left > 0) begin
          waitrequest = 1'b1;
          wait_left--;
        end else begin
          waitrequest = 1'b0;
        end
      end
      if (resp_valid === 1'b1) begin
        got = 1'b1; r_lat = n; r_data = resp_data; r_err = resp_err;
      end else begin
        @(negedge clk);
      end
    end
    waitrequest = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout op=%0d addr=%h actual=no_resp required=resp", op, addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = '0;
    req_wdata = '0; req_rt = '0; waitrequest = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready actual=%b required=1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, read, write} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes actual=%b required=0000", {resp_valid, resp_err, read, write});
    end
    checks++;
    if (address !== 32'h0 || writedata !== 32'h0 || byteenable !== 4'h0 || resp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus actual=%h/%h/%h/%h required=0", address, writedata, byteenable, resp_data);
    end
  endtask

  task automatic test_sw();
    do_req(4'd10, 32'hBFC0_0010, 32'h1234_5678, 32'h0, 0);
    checks++;
    if (r_wr !== 1 || r_rd !== 0) begin errors++; $display("FAIL sw_strobes actual=wr%0d rd%0d required=wr1 rd0", r_wr, r_rd); end
    checks++;
    if (r_be !== 4'b1111 || r_addr !== 32'hBFC0_0010 || r_wd !== 32'h1234_5678) begin
      errors++; $display("FAIL sw_bus actual=%b/%h/%h required=1111/bfc00010/12345678", r_be, r_addr, r_wd);
    end
    checks++;
    if (r_lat !== 2 || r_err !== 1'b0 || r_data !== 32'h0) begin
      errors++; $display("FAIL sw_resp actual=lat%0d err%b data%h required=lat2 err0 data0", r_lat, r_err, r_data);
    end
  endtask

  task automatic test_byte();
    do_req(4'd8, 32'hBFC0_0013, 32'h0000_00AB, 32'h0, 0);
    checks++;
    if (r_be !== 4'b1000 || r_wd !== 32'hABAB_ABAB || r_lat !== 2) begin
      errors++; $display("FAIL sb_bus actual=%b/%h lat%0d required=1000/ababab ab lat2", r_be, r_wd, r_lat);
    end
    do_req(4'd0, 32'hBFC0_0013, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'hFFFF_FFAB || r_lat !== 3 || r_be !== 4'b1000 || r_rd !== 1) begin
      errors++; $display("FAIL lb_sext actual=%h lat%0d be%b required=ffffffab lat3 be1000", r_data, r_lat, r_be);
    end
    do_req(4'd1, 32'hBFC0_0013, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'h0000_00AB || r_err !== 1'b0) begin
      errors++; $display("FAIL lbu_zext actual=%h err%b required=000000ab err0", r_data, r_err);
    end
  endtask

  task automatic test_half();
    do_req(4'd10, 32'hBFC0_0010, 32'h8001_9234, 32'h0, 0);
    do_req(4'd2, 32'hBFC0_0012, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'hFFFF_8001 || r_be !== 4'b1100 || r_addr !== 32'hBFC0_0010) begin
      errors++; $display("FAIL lh_hi actual=%h be%b addr%h required=ffff8001 be1100 addrbfc00010", r_data, r_be, r_addr);
    end
    do_req(4'd3, 32'hBFC0_0012, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_hi actual=%h required=00008001", r_data); end
    do_req(4'd2, 32'hBFC0_0010, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'hFFFF_9234 || r_be !== 4'b0011) begin
      errors++; $display("FAIL lh_lo actual=%h be%b required=ffff9234 be0011", r_data, r_be);
    end
    do_req(4'd9, 32'hBFC0_0012, 32'h0000_BEEF, 32'h0, 0);
    checks++;
    if (r_wd !== 32'hBEEF_BEEF || r_be !== 4'b1100) begin
      errors++; $display("FAIL sh_bus actual=%h be%b required=beefbeef be1100", r_wd, r_be);
    end
  endtask

  task automatic test_errors();
    do_req(4'd4, 32'hBFC0_0002, 32'h0, 32'h0, 0);
    checks++;
    if (r_rd !== 0 || r_wr !== 0 || r_lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0) begin
      errors++; $display("FAIL lw_misaligned actual=rd%0d wr%0d lat%0d err%b data%h required=0 0 1 1 0", r_rd, r_wr, r_lat, r_err, r_data);
    end
    do_req(4'd7, 32'hBFC0_0010, 32'h0, 32'h0, 0);
    checks++;
    if (r_rd !== 0 || r_wr !== 0 || r_lat !== 1 || r_err !== 1'b1) begin
      errors++; $display("FAIL illegal_op7 actual=rd%0d wr%0d lat%0d err%b required=0 0 1 1", r_rd, r_wr, r_lat, r_err);
    end
    do_req(4'd9, 32'hBFC0_0011, 32'h1111_1111, 32'h0, 0);
    checks++;
    if (r_wr !== 0 || r_err !== 1'b1 || r_lat !== 1) begin
      errors++; $display("FAIL sh_misaligned actual=wr%0d err%b lat%0d required=0 1 1", r_wr, r_err, r_lat);
    end
  endtask

  task automatic test_unaligned_merge();
    do_req(4'd10, 32'hBFC0_0010, 32'hAABB_CCDD, 32'h0, 0);
    do_req(4'd5, 32'hBFC0_0011, 32'h0, 32'h1122_3344, 0);
    checks++;
    if (r_data !== 32'hCCDD_3344 || r_be !== 4'b1111) begin
      errors++; $display("FAIL lwl_k1 actual=%h be%b required=ccdd3344 be1111", r_data, r_be);
    end
    do_req(4'd6, 32'hBFC0_0011, 32'h0, 32'h1122_3344, 0);
    checks++;
    if (r_data !== 32'h11AA_BBCC) begin errors++; $display("FAIL lwr_k1 actual=%h required=11aabbcc", r_data); end
    do_req(4'd5, 32'hBFC0_0013, 32'h0, 32'h1122_3344, 0);
    checks++;
    if (r_data !== 32'hAABB_CCDD) begin errors++; $display("FAIL lwl_k3 actual=%h required=aabbccdd", r_data); end
  endtask

  task automatic test_back_to_back();
    // each do_req returns in the resp_valid cycle and the next one issues there
    do_req(4'd10, 32'hBFC0_0014, 32'hCAFE_F00D, 32'h0, 0);
    do_req(4'd4, 32'hBFC0_0014, 32'h0, 32'h0, 0);
    checks++;
    if (r_data !== 32'hCAFE_F00D || r_lat !== 3) begin
      errors++; $display("FAIL b2b_lw actual=%h lat%0d required=cafef00d lat3", r_data, r_lat);
    end
  endtask

  task automatic test_wait();
    do_req(4'd4, 32'hBFC0_0010, 32'h0, 32'h0, 3);
    checks++;
    if (r_rd !== 4 || r_stable !== 1'b1 || r_addr !== 32'hBFC0_0010) begin
      errors++; $display("FAIL wait_read_hold actual=rd%0d stable%b addr%h required=4 1 bfc00010", r_rd, r_stable, r_addr);
    end
    checks++;
    if (r_lat !== 6 || r_data !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL wait_latency actual=lat%0d data%h required=lat6 aabbccdd", r_lat, r_data);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_addr = 32'hBFC0_0010;
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL mid_read_active actual=%b required=1", read); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || address !== 32'h0) begin
      errors++; $display("FAIL mid_async_drop actual=read%b addr%h required=0 0", read, address);
    end
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_no_resp actual=resp%0d ready%b required=0 1", seen, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_byte();
    test_half();
    test_errors();
    test_unaligned_merge();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Load/store unit sitting directly upstream of the 32x65536 Avalon-style data RAM. It accepts one memory request at a time from the CPU execute stage and drives the RAM's read/write/address/byteenable/writedata bus, stalling while waitrequest is high. For loads it extracts, sign/zero-extends or merges the returned word and hands a result back to the core with a one-cycle response pulse. Memory is little-endian: byte offset k maps to byteenable[k] and data bits [8k+7:8k].

Parameters:
ADDR_W, 32, address and data width; fixed at 32 for this core.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  LSU can accept (high only in IDLE)
req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; others illegal
req_addr  in  32  byte address
req_wdata  in  32  store data (rt), low bits used for SB/SH
req_rt  in  32  current rt value, merge source for LWL/LWR
resp_valid  out  1  one-cycle result pulse
resp_data  out  32  load result (0 for stores/errors)
resp_err  out  1  misaligned or illegal op; valid with resp_valid
address  out  32  word-aligned bus address
read  out  1  bus read strobe
write  out  1  bus write strobe
waitrequest  in  1  slave stall
writedata  out  32  lane-replicated store data
byteenable  out  4  active byte lanes
readdata  in  32  registered RAM data, valid the cycle after read is accepted; disabled lanes read as 0

Behaviour:
- Reset (async, reset_n low): state IDLE; req_ready=1 once released; resp_valid=0, resp_data=0, resp_err=0, read=0, write=0, address=0, writedata=0, byteenable=0. Reset mid-transaction abandons it immediately; no response ever issued for it.
- States: IDLE, READ, WRITE, RDATA.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at posedge; latch op, addr, wdata, rt.
  - Illegal op, or misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus access; next cycle resp_valid=1, resp_err=1, resp_data=0; stay IDLE.
  - Legal load -> READ; legal store -> WRITE.
- READ: read=1, address={addr[31:2],2'b00}, byteenable per op; held stable while waitrequest=1. Posedge with waitrequest=0 -> RDATA.
- RDATA: read=0; readdata valid. Posedge registers resp_data, resp_valid=1, resp_err=0 -> IDLE.
- WRITE: write=1, address/byteenable/writedata held stable while waitrequest=1. Posedge with waitrequest=0 -> resp_valid=1, resp_data=0, resp_err=0 -> IDLE.
- Bus outputs (address, writedata, byteenable) are 0 outside READ/WRITE.
- resp_valid is high exactly one cycle; a new request may be accepted in that same cycle.
- Latency at waitrequest=0, counting accept edge as 0: store resp_valid in cycle 2, load in cycle 3, error in cycle 1. Each waitrequest-high cycle adds one.
- Byteenable: LB/LBU/SB 1<<k (k=addr[1:0]); LH/LHU/SH 0011 (k=0) or 1100 (k=2); LW/LWL/LWR/SW 1111.
- Writedata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load results (w = readdata, k = addr[1:0]): LB sext(w byte k); LBU zext(w byte k); LH/LHU sext/zext(w halfword k/2); LW w; LWL (w << 8(3-k)) | (rt & low 8(3-k) bits); LWR (w >> 8k) | (rt & high 8k bits).
- req_op/addr changes after handshake are ignored.

Test Plan:
- SW addr BFC00010 wdata 12345678, waitrequest=0 -> write=1 one cycle, byteenable 1111, address BFC00010; resp_valid cycle 2, resp_err 0.
- SB addr BFC00013 wdata 000000AB -> byteenable 1000, writedata ABABABAB; then LB BFC00013 -> resp_data FFFFFFAB; LBU -> 000000AB.
- LH BFC00012 with word 8001_xxxx -> byteenable 1100, resp_data FFFF8001; LHU -> 00008001.
- LW BFC00002 -> no read/write asserted, resp_valid next cycle, resp_err 1; op 7 likewise.
- LWL BFC00011, word AABBCCDD, rt 11223344 -> resp_data CCDD3344; LWR same addr -> 11AABBCC.
- LW with waitrequest held high 3 cycles -> read and address stable 4 cycles, resp_valid cycle 6; reset_n low during READ -> read drops asynchronously, no resp_valid afterwards.
